// File: rtl/runner_pkg.sv
// Shared screen geometry, FSM encoding and LFSR definition for the runner game.
package runner_pkg;

  localparam int H_ACTIVE   = 640;
  localparam int V_ACTIVE   = 480;
  localparam int NUM_BLOCKS = 16;

  localparam logic [15:0] LFSR_MASK = 16'hB400;

  typedef enum logic [1:0] {
    PLAY   = 2'd0,
    GOAL   = 2'd1,
    FROZEN = 2'd2
  } state_t;

  // Right-shifting Galois step: the bit shifted out selects the feedback mask.
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? LFSR_MASK : 16'h0000);
  endfunction

endpackage

// File: rtl/obstacle_lfsr.sv
// 16-bit Galois LFSR supplying respawn heights; seed reloaded on rst, steps when enabled.
module obstacle_lfsr
  import runner_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       step,
  output logic [8:0] offset
);

  logic [15:0] lfsr;

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= SEED;
    end else if (step) begin
      lfsr <= lfsr_next(lfsr);
    end
  end

  // Height offset above the top border, 0..318; reflects the value before this tick's step.
  assign offset = {1'b0, lfsr[7:0]} + {3'b000, lfsr[15:10]};

endmodule

// File: rtl/obstacle_field.sv
// Scrolling obstacle field, border bands and end zone, drawn per pixel with one clock of latency.
module obstacle_field
  import runner_pkg::*;
#(
  parameter int          BLK_W       = 32,
  parameter int          BLK_H       = 32,
  parameter int          SPACING     = 40,
  parameter int          SPEED       = 2,
  parameter int          BORDER_H    = 16,
  parameter int          END_W       = 32,
  parameter int          END_STOP_X  = 600,
  parameter int          GOAL_FRAMES = 1800,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [9:0]            xCount,
  input  logic [9:0]            yCount,
  input  logic                  frame_tick,
  input  logic                  win,
  input  logic                  game_over,
  output logic [NUM_BLOCKS-1:0] blocks,
  output logic                  border,
  output logic                  end_zone,
  output logic [1:0]            state_dbg
);

  localparam logic [10:0] BW       = 11'(BLK_W);
  localparam logic [10:0] BH       = 11'(BLK_H);
  localparam logic [10:0] SPD      = 11'(SPEED);
  localparam logic [10:0] WRAP     = 11'(16 * SPACING);
  localparam logic [10:0] EW       = 11'(END_W);
  localparam logic [10:0] EZ_START = 11'(H_ACTIVE + END_W);
  localparam logic [10:0] EZ_STOP  = 11'(END_STOP_X);
  localparam logic [10:0] BAND_TOP = 11'(BORDER_H);
  localparam logic [10:0] BAND_BOT = 11'(V_ACTIVE - BORDER_H);
  localparam logic [10:0] FC_LAST  = 11'(GOAL_FRAMES - 1);
  localparam logic [10:0] FC_MAX   = 11'h7FF;

  state_t          state;
  logic [10:0]     frame_cnt;
  logic [10:0]     ez_rx;
  logic [8:0]      lfsr_offset;
  logic [8:0]      respawn_y;
  logic            freeze_req;
  logic            move;
  logic [10:0]     x11;
  logic [10:0]     y11;
  logic            visible;
  logic            ez_hit;
  logic [NUM_BLOCKS-1:0] hit;

  assign x11        = {1'b0, xCount};
  assign y11        = {1'b0, yCount};
  assign visible    = (x11 < 11'(H_ACTIVE)) && (y11 < 11'(V_ACTIVE));
  assign freeze_req = win || game_over;
  // A freeze request on a tick wins: nothing moves on that tick.
  assign move       = frame_tick && !freeze_req && (state != FROZEN);
  assign respawn_y  = 9'(BORDER_H) + lfsr_offset;
  assign state_dbg  = state;

  obstacle_lfsr #(
    .SEED(LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .step  (move),
    .offset(lfsr_offset)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= PLAY;
      frame_cnt <= '0;
      ez_rx     <= '0;
    end else if (state != FROZEN && freeze_req) begin
      state <= FROZEN;
    end else if (frame_tick) begin
      case (state)
        PLAY: begin
          if (frame_cnt != FC_MAX) frame_cnt <= frame_cnt + 11'd1;
          if (frame_cnt == FC_LAST) begin
            state <= GOAL;
            ez_rx <= EZ_START;
          end
        end
        GOAL: begin
          if (ez_rx >= EZ_STOP + SPD) ez_rx <= ez_rx - SPD;
          else                        ez_rx <= EZ_STOP;
        end
        default: ;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BLOCKS; gi++) begin : g_blk
      logic [10:0] rx_q;
      logic [8:0]  y_q;
      logic        act_q;
      logic [10:0] top11;

      always_ff @(posedge clk) begin
        if (rst) begin
          rx_q  <= 11'(H_ACTIVE + BLK_W + gi * SPACING);
          y_q   <= 9'(BORDER_H + 8 * gi);
          act_q <= 1'b1;
        end else if (move) begin
          if (rx_q > SPD) begin
            rx_q <= rx_q - SPD;
          end else begin
            rx_q <= rx_q - SPD + WRAP;
            if (state == GOAL) act_q <= 1'b0;
            else               y_q   <= respawn_y;
          end
        end
      end

      assign top11   = {2'b00, y_q};
      assign hit[gi] = act_q && (x11 < rx_q) && (x11 + BW >= rx_q) &&
                       (top11 <= y11) && (y11 < top11 + BH);
    end
  endgenerate

  assign ez_hit = (state != PLAY) && (x11 < ez_rx) && (x11 + EW >= ez_rx) &&
                  (y11 >= BAND_TOP) && (y11 < BAND_BOT);

  always_ff @(posedge clk) begin
    if (rst) begin
      blocks   <= '0;
      border   <= 1'b0;
      end_zone <= 1'b0;
    end else begin
      blocks   <= visible ? hit : '0;
      border   <= visible && ((y11 < BAND_TOP) || (y11 >= BAND_BOT));
      end_zone <= visible && ez_hit;
    end
  end

endmodule

// File: tb/tb_obstacle_field.sv
// Randomized bench for obstacle_field against a frame-level model of the obstacle field.
module tb_obstacle_field;

  localparam int GF = 400;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  xc = '0;
  logic [9:0]  yc = '0;
  logic        frame_tick = 1'b0;
  logic        win = 1'b0;
  logic        game_over = 1'b0;
  logic [15:0] blocks;
  logic        border;
  logic        end_zone;
  logic [1:0]  state_dbg;

  always #5 clk = ~clk;

  obstacle_field #(.GOAL_FRAMES(GF)) dut (
    .clk       (clk),
    .rst       (rst),
    .xCount    (xc),
    .yCount    (yc),
    .frame_tick(frame_tick),
    .win       (win),
    .game_over (game_over),
    .blocks    (blocks),
    .border    (border),
    .end_zone  (end_zone),
    .state_dbg (state_dbg)
  );

  // Model: mode 0 = playing, 1 = goal run-in, 2 = frozen.
  int          m_rx[16];
  int          m_y[16];
  bit          m_act[16];
  int          m_lfsr;
  int          m_mode;
  int          m_fc;
  int          m_ez;
  int          n_checks = 0;
  int          n_pass = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) begin
      m_rx[i]  = 640 + 32 + i * 40;
      m_y[i]   = 16 + 8 * i;
      m_act[i] = 1'b1;
    end
    m_lfsr = 'hACE1;
    m_mode = 0;
    m_fc   = 0;
    m_ez   = 0;
  endfunction

  function automatic void model_tick();
    int h;
    if (m_mode == 2) return;
    h = 16 + (m_lfsr % 256) + (m_lfsr / 1024);
    for (int i = 0; i < 16; i++) begin
      if (m_rx[i] > 2) m_rx[i] -= 2;
      else begin
        m_rx[i] += 638;
        if (m_mode == 1) m_act[i] = 1'b0;
        else m_y[i] = h;
      end
    end
    m_lfsr = (m_lfsr % 2 == 1) ? ((m_lfsr / 2) ^ 'hB400) : (m_lfsr / 2);
    if (m_mode == 0) begin
      if (m_fc == GF - 1) begin
        m_mode = 1;
        m_ez   = 672;
      end
      if (m_fc < 2047) m_fc++;
    end else begin
      m_ez = (m_ez - 2 < 600) ? 600 : m_ez - 2;
    end
  endfunction

  function automatic logic [17:0] model_px(input int x, input int y);
    logic [15:0] b;
    logic bd, ez;
    b = '0;
    if (x >= 640 || y >= 480) return '0;
    for (int i = 0; i < 16; i++)
      b[i] = m_act[i] && x < m_rx[i] && x + 32 >= m_rx[i] && m_y[i] <= y && y < m_y[i] + 32;
    bd = (y < 16) || (y >= 464);
    ez = (m_mode != 0) && x < m_ez && x + 32 >= m_ez && y >= 16 && y < 464;
    return {b, bd, ez};
  endfunction

  task automatic probe(input int x, input int y, input string tag);
    if (x < 0 || x > 1023 || y < 0 || y > 1023) return;
    @(negedge clk);
    xc = 10'(x);
    yc = 10'(y);
    exp_q.push_back(32'(model_px(x, y)));
    @(negedge clk);
    check($sformatf("%s(%0d,%0d)", tag, x, y), 32'({blocks, border, end_zone}), exp_q.pop_front());
  endtask

  task automatic tick();
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    model_tick();
  endtask

  task automatic freeze_tick(input logic w, input logic g);
    @(negedge clk);
    frame_tick = 1'b1;
    win        = w;
    game_over  = g;
    @(negedge clk);
    frame_tick = 1'b0;
    win        = 1'b0;
    game_over  = 1'b0;
    m_mode     = 2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic edge_probes(input int n, input string tag);
    int i;
    for (int k = 0; k < n; k++) begin
      i = $urandom_range(0, 15);
      probe(m_rx[i] - 1, m_y[i], tag);
      probe(m_rx[i] - 32, m_y[i] + 31, tag);
      probe(m_rx[i] - 33, m_y[i] + 5, tag);
      probe(m_rx[i], m_y[i] + 5, tag);
      probe(m_rx[i] - 10, m_y[i] - 1, tag);
      probe(m_rx[i] - 10, m_y[i] + 32, tag);
      probe($urandom_range(0, 700), $urandom_range(0, 500), tag);
    end
  endtask

  initial begin
    int guard;
    logic [31:0] held[$];

    // 1: reset state and a sparse full-frame scan with no ticks
    do_reset();
    check("rst_outputs", 32'({blocks, border, end_zone}), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);
    for (int y = 0; y < 525; y += 15)
      for (int x = 0; x < 800; x += 20) probe(x, y, "scan");
    probe(100, 5, "border_on");
    probe(700, 5, "border_off");
    probe(100, 470, "border_bot");

    // 2: block 0 reaches the right edge after 16 ticks
    for (int k = 0; k < 16; k++) tick();
    probe(620, m_y[0] + 1, "blk0_in");
    probe(607, m_y[0] + 1, "blk0_out");
    probe(608, m_y[0] + 1, "blk0_left");
    edge_probes(4, "play");

    // 3: drive block 0 to rx=2, then wrap with the pre-step LFSR height
    guard = 0;
    while (m_rx[0] != 2 && guard < 1000) begin
      tick();
      guard++;
      if (guard % 40 == 0) edge_probes(1, "scroll");
    end
    check("reach_rx2", 32'(m_rx[0]), 32'd2);
    probe(1, m_y[0] + 3, "blk0_at2");
    tick();
    probe(639, m_y[0], "wrap_top");
    probe(639, m_y[0] - 1, "wrap_above");
    probe(639, m_y[0] + 31, "wrap_bot");
    probe(639, m_y[0] + 32, "wrap_below");

    // 4: enter GOAL, end zone scrolls in and clamps, wrapped blocks vanish
    guard = 0;
    while (m_mode != 1 && guard < 1000) begin
      tick();
      guard++;
      if (guard % 25 == 0) edge_probes(1, "pregoal");
    end
    check("goal_state", 32'(state_dbg), 32'(m_mode));
    probe(639, 240, "ez_enter");
    tick();
    probe(639, 240, "ez_first");
    probe(639, 15, "ez_above");
    probe(639, 464, "ez_below");
    for (int k = 0; k < 40; k++) begin
      tick();
      probe(m_ez - 1, $urandom_range(16, 463), "ez_in");
      probe(m_ez - 33, 200, "ez_left");
    end
    probe(599, 240, "ez_clamp_in");
    probe(600, 240, "ez_clamp_out");
    probe(567, 240, "ez_clamp_left");
    for (int k = 0; k < 300; k++) begin
      tick();
      if (k % 30 == 0) edge_probes(2, "goal");
    end
    for (int y = 16; y < 464; y += 24)
      for (int x = 0; x < 640; x += 16) probe(x, y, "vanish");

    // 5: game_over on a tick freezes everything
    freeze_tick(1'b0, 1'b1);
    check("frozen_state", 32'(state_dbg), 32'd2);
    for (int y = 0; y < 480; y += 40) begin
      @(negedge clk);
      xc = 10'(599);
      yc = 10'(y);
      @(negedge clk);
      held.push_back(32'({blocks, border, end_zone}));
    end
    for (int k = 0; k < 5; k++) tick();
    for (int y = 0; y < 480; y += 40) probe(599, y, "frozen_hold");
    edge_probes(3, "frozen");

    // 6: rst mid-GOAL restores reset values
    do_reset();
    for (int k = 0; k < GF + 5; k++) tick();
    check("goal_again", 32'(state_dbg), 32'(m_mode));
    @(negedge clk);
    rst = 1'b1;
    xc  = 10'(100);
    yc  = 10'(5);
    @(negedge clk);
    check("midrst_outputs", 32'({blocks, border, end_zone}), 32'd0);
    check("midrst_state", 32'(state_dbg), 32'd0);
    rst = 1'b0;
    model_reset();
    probe(100, 5, "post_rst_border");
    for (int k = 0; k < 16; k++) tick();
    probe(620, m_y[0] + 1, "post_rst_blk0");
    for (int k = 0; k < 320; k++) tick();
    edge_probes(3, "post_rst_wrap");

    // win latches exactly like game_over
    freeze_tick(1'b1, 1'b0);
    check("win_state", 32'(state_dbg), 32'd2);
    for (int k = 0; k < 5; k++) tick();
    edge_probes(4, "win_hold");
    check("win_still", 32'(state_dbg), 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
